// File: rtl/alu_acc16_pkg.sv
// Shared definitions for the 16-bit accumulator ALU: opcodes, FSM states, flag indices.
package alu_acc16_pkg;

  localparam int DATA_W = 16;
  localparam int SH_W   = 4;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit positions inside FLAGS = {Z,N,C,V}
  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/addsub16.sv
// Combinational add/subtract with carry-or-borrow and signed-overflow outputs.
// For subtraction, carry reports a borrow (a < b unsigned), not the raw carry-out.
module addsub16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic             carry_out;

  // a + b, or a + ~b + 1 for subtraction
  always_comb begin
    b_eff              = sub ? ~b : b;
    {carry_out, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    carry              = sub ? ~carry_out : carry_out;
    overflow           = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_acc16.sv
// 16-bit accumulator ALU. Single-cycle ops update ACC/FLAGS at the accept edge;
// shifts by n>=1 run one bit per cycle in ST_SHIFT and complete after n edges.
//
// Handshake: an op is accepted on a rising edge where IN_VALID && IN_READY.
// IN_READY is high only in ST_IDLE and not in reset. While IN_READY is low,
// IN_VALID is ignored and nothing is latched; OP/B_IN/SHAMT are sampled only
// at the accept edge. OUT_VALID pulses for one cycle after each completion.
module alu_acc16
  import alu_acc16_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = SH_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [2:0]         OP,
  input  logic [WIDTH-1:0]   B_IN,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic [WIDTH-1:0]   ACC,
  output logic [3:0]         FLAGS,
  output logic               OUT_VALID,
  output logic               BUSY
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_right_q, dir_right_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH-1:0]   as_sum;
  logic               as_carry;
  logic               as_ovf;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               done;
  logic [WIDTH-1:0]   shifted;
  logic               shift_out_bit;

  assign IN_READY  = (state_q == ST_IDLE) && !RST;
  assign accept    = IN_VALID && IN_READY;
  assign ACC       = acc_q;
  assign FLAGS     = flags_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = (state_q == ST_SHIFT);

  addsub16 #(.WIDTH(WIDTH)) u_addsub (
    .a        (acc_q),
    .b        (B_IN),
    .sub      (OP == OP_SUB),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  // Next-state, accumulator and flag computation
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    dir_right_d   = dir_right_q;
    acc_d         = acc_q;
    flags_d       = flags_q;
    out_valid_d   = 1'b0;
    res           = acc_q;
    res_c         = 1'b0;
    res_v         = 1'b0;
    done          = 1'b0;
    shifted       = dir_right_q ? (acc_q >> 1) : (acc_q << 1);
    shift_out_bit = dir_right_q ? acc_q[0] : acc_q[WIDTH-1];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done = 1'b1;
          case (OP)
            OP_PASS: res = B_IN;
            OP_ADD, OP_SUB: begin
              res   = as_sum;
              res_c = as_carry;
              res_v = as_ovf;
            end
            OP_AND:  res = acc_q & B_IN;
            OP_OR:   res = acc_q | B_IN;
            OP_XOR:  res = acc_q ^ B_IN;
            default: begin
              // SHL/SHR: a zero shift completes now with C=0, otherwise iterate
              if (SHAMT != '0) begin
                done        = 1'b0;
                state_d     = ST_SHIFT;
                count_d     = SHAMT;
                dir_right_d = (OP == OP_SHR);
              end
            end
          endcase
          if (done) begin
            acc_d       = res;
            flags_d     = {(res == '0), res[WIDTH-1], res_c, res_v};
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        acc_d   = shifted;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d     = ST_IDLE;
          flags_d     = {(shifted == '0), shifted[WIDTH-1], shift_out_bit, 1'b0};
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      dir_right_q <= 1'b0;
      acc_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dir_right_q <= dir_right_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
